reg8file_seq: RTL and testbench

Command sequencer that drives the 8×8-bit register file (`reg8file`) through its write port (`en`, `wsel`, `d`), read port (`rsel`, `q`) and clear (`clr`). It accepts one command at a time from a host over a valid/ready handshake: write-immediate, read, add, or clear. It breaks each command into register-file cycles and returns a result over a valid/ready response channel. It sits between the lab top-level host logic and one `reg8file` instance.

---
 rtl/reg8file_pkg.sv | 20 ++
 rtl/reg8file_seq_if.sv | 35 +++
 rtl/reg8file_seq.sv | 122 ++++++++++++
 tb/tb_reg8file_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg8file_pkg.sv
// Shared constants for the reg8file command sequencer:
// widths, host op encoding and controller state encoding.
package reg8file_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    localparam logic [1:0] OP_WRI = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_CLR  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

endpackage

// File: rtl/reg8file_seq_if.sv
// Host-side command/response channel of the register-file sequencer.
// master = host, slave = sequencer.
interface reg8file_seq_if #(
    parameter int DW = 8,
    parameter int AW = 3
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_carry,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_carry,
        input  rsp_ready
    );

endinterface

// File: rtl/reg8file_seq.sv
// Sequencer that turns host commands (WRI/RD/ADD/CLR) into reg8file
// write/read/clear cycles and returns one response per command.
module reg8file_seq
    import reg8file_pkg::*;
#(
    parameter int DW = reg8file_pkg::DW,
    parameter int AW = reg8file_pkg::AW
) (
    input  logic          clk,
    input  logic          clr_n,
    reg8file_seq_if.slave bus,
    output logic          rf_clr,
    output logic          rf_en,
    output logic [AW-1:0] rf_wsel,
    output logic [DW-1:0] rf_d,
    output logic [AW-1:0] rf_rsel,
    input  logic [DW-1:0] rf_q
);

    logic [2:0]    state;
    logic [1:0]    op_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] rf_d_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_carry_q;
    logic [DW:0]   sum;
    logic          accept;

    assign bus.cmd_ready = (state == S_IDLE) && clr_n;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;

    assign sum = {1'b0, a_q} + {1'b0, rf_q};

    // ADD writes back the live sum in RD2, so rf_d bypasses its hold register there
    assign rf_en  = (state == S_WR) || (state == S_RD2);
    assign rf_clr = (state == S_CLR);
    assign rf_d   = (state == S_RD2) ? sum[DW-1:0] : rf_d_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state       <= S_IDLE;
            op_q        <= OP_WRI;
            rs2_q       <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            rf_d_q      <= '0;
            rf_wsel     <= '0;
            rf_rsel     <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.cmd_op;
                        rs2_q <= bus.cmd_rs2;
                        imm_q <= bus.cmd_imm;
                        unique case (bus.cmd_op)
                            OP_WRI: begin
                                state   <= S_WR;
                                rf_wsel <= bus.cmd_rd;
                                rf_d_q  <= bus.cmd_imm;
                            end
                            OP_RD: begin
                                state   <= S_RD1;
                                rf_rsel <= bus.cmd_rs1;
                            end
                            OP_ADD: begin
                                state   <= S_RD1;
                                rf_rsel <= bus.cmd_rs1;
                                rf_wsel <= bus.cmd_rd;
                            end
                            OP_CLR: begin
                                state <= S_CLR;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_WR: begin
                    rsp_data_q  <= imm_q;
                    rsp_carry_q <= 1'b0;
                    state       <= S_RESP;
                end
                S_RD1: begin
                    if (op_q == OP_ADD) begin
                        a_q     <= rf_q;
                        rf_rsel <= rs2_q;
                        state   <= S_RD2;
                    end else begin
                        rsp_data_q  <= rf_q;
                        rsp_carry_q <= 1'b0;
                        state       <= S_RESP;
                    end
                end
                S_RD2: begin
                    rf_d_q      <= sum[DW-1:0];
                    rsp_data_q  <= sum[DW-1:0];
                    rsp_carry_q <= sum[DW];
                    state       <= S_RESP;
                end
                S_CLR: begin
                    rsp_data_q  <= '0;
                    rsp_carry_q <= 1'b0;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg8file_seq.sv
// Directed bench for reg8file_seq with a behavioural 8x8 register file
// attached to its rf_* port.
module tb_reg8file_seq;

    logic       clk;
    logic       clr_n;
    logic       rf_clr;
    logic       rf_en;
    logic [2:0] rf_wsel;
    logic [7:0] rf_d;
    logic [2:0] rf_rsel;
    logic [7:0] rf_q;

    logic [7:0] regs [8];

    int errors;
    int checks;
    int en_cnt;
    int clr_cnt;
    logic [2:0] en_wsel;

    reg8file_seq_if #(.DW(8), .AW(3)) bus ();

    reg8file_seq dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus     (bus),
        .rf_clr  (rf_clr),
        .rf_en   (rf_en),
        .rf_wsel (rf_wsel),
        .rf_d    (rf_d),
        .rf_rsel (rf_rsel),
        .rf_q    (rf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (rf_en) begin
            regs[rf_wsel] <= rf_d;
        end
    end

    assign rf_q = regs[rf_rsel];

    always @(negedge clk) begin
        if (rf_en === 1'b1) begin
            en_cnt  = en_cnt + 1;
            en_wsel = rf_wsel;
        end
        if (rf_clr === 1'b1) clr_cnt = clr_cnt + 1;
    end

    task automatic run_cmd(
        input  logic [1:0] op,
        input  logic [2:0] rd,
        input  logic [2:0] rs1,
        input  logic [2:0] rs2,
        input  logic [7:0] imm,
        input  logic       rdy,
        output logic [7:0] data,
        output logic       carry,
        output int         lat
    );
        int n;
        @(negedge clk);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: cmd_ready=%b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.rsp_ready = rdy;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data  = bus.rsp_data;
        carry = bus.rsp_carry;
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b want 0 0", bus.cmd_ready, bus.rsp_valid);
        end
        checks++;
        if (rf_en !== 1'b0 || rf_clr !== 1'b0 || rf_d !== 8'h00
            || rf_wsel !== 3'd0 || rf_rsel !== 3'd0) begin
            errors++;
            $display("FAIL reset_rf: en=%b clr=%b d=%h ws=%0d rs=%0d want all 0",
                     rf_en, rf_clr, rf_d, rf_wsel, rf_rsel);
        end
        checks++;
        if (bus.rsp_data !== 8'h00 || bus.rsp_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: data=%h carry=%b want 00 0", bus.rsp_data, bus.rsp_carry);
        end
        clr_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_wri_rd;
        logic [7:0] d;
        logic       c;
        int         lat;
        int         e0;
        e0 = en_cnt;
        run_cmd(2'b00, 3'd3, 3'd0, 3'd0, 8'h5A, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h5A || c !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL wri: data=%h carry=%b lat=%0d want 5a 0 2", d, c, lat);
        end
        checks++;
        if (en_cnt - e0 != 1 || en_wsel !== 3'd3) begin
            errors++;
            $display("FAIL wri_en: pulses=%0d wsel=%0d want 1 3", en_cnt - e0, en_wsel);
        end
        run_cmd(2'b01, 3'd0, 3'd3, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h5A || c !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL rd: data=%h carry=%b lat=%0d want 5a 0 2", d, c, lat);
        end
        checks++;
        if (en_cnt - e0 != 1) begin
            errors++;
            $display("FAIL rd_no_write: pulses=%0d want 1", en_cnt - e0);
        end
    endtask

    task automatic test_add_wrap;
        logic [7:0] d;
        logic       c;
        int         lat;
        run_cmd(2'b00, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b1, d, c, lat);
        run_cmd(2'b00, 3'd2, 3'd0, 3'd0, 8'h01, 1'b1, d, c, lat);
        run_cmd(2'b10, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h00 || c !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL add_wrap: data=%h carry=%b lat=%0d want 00 1 3", d, c, lat);
        end
        checks++;
        if (en_wsel !== 3'd4) begin
            errors++;
            $display("FAIL add_wsel: wsel=%0d want 4", en_wsel);
        end
        run_cmd(2'b01, 3'd0, 3'd4, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h00 || c !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap_rd: data=%h carry=%b want 00 0", d, c);
        end
        run_cmd(2'b10, 3'd6, 3'd2, 3'd2, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h02 || c !== 1'b0) begin
            errors++;
            $display("FAIL add_plain: data=%h carry=%b want 02 0", d, c);
        end
    endtask

    task automatic test_alias;
        logic [7:0] d;
        logic       c;
        int         lat;
        run_cmd(2'b00, 3'd5, 3'd0, 3'd0, 8'h10, 1'b1, d, c, lat);
        run_cmd(2'b10, 3'd5, 3'd5, 3'd5, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h20 || c !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL alias_add: data=%h carry=%b lat=%0d want 20 0 3", d, c, lat);
        end
        run_cmd(2'b01, 3'd0, 3'd5, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h20) begin
            errors++;
            $display("FAIL alias_rd: data=%h want 20", d);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] d;
        logic       c;
        int         lat;
        int         e0;
        run_cmd(2'b00, 3'd6, 3'd0, 3'd0, 8'h77, 1'b0, d, c, lat);
        e0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h77 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b data=%h ready=%b want 1 77 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready);
            end
            bus.cmd_valid = (i == 2);
            bus.cmd_op    = 2'b00;
            bus.cmd_rd    = 3'd7;
            bus.cmd_imm   = 8'hEE;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (en_cnt != e0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ignored: writes=%0d ready=%b want 0 1", en_cnt - e0, bus.cmd_ready);
        end
    endtask

    task automatic test_clr;
        logic [7:0] d;
        logic       c;
        logic [7:0] v;
        int         lat;
        int         c0;
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h11 * (i + 1));
            run_cmd(2'b00, 3'(i), 3'd0, 3'd0, v, 1'b1, d, c, lat);
        end
        run_cmd(2'b01, 3'd0, 3'd7, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h88) begin
            errors++;
            $display("FAIL fill_r7: data=%h want 88", d);
        end
        c0 = clr_cnt;
        run_cmd(2'b11, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h00 || c !== 1'b0 || lat != 2 || clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL clr: data=%h carry=%b lat=%0d pulses=%0d want 00 0 2 1",
                     d, c, lat, clr_cnt - c0);
        end
        for (int i = 0; i < 8; i++) begin
            run_cmd(2'b01, 3'd0, 3'(i), 3'd0, 8'h00, 1'b1, d, c, lat);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL clr_rd_r%0d: data=%h want 00", i, d);
            end
        end
    endtask

    task automatic test_reset_mid_add;
        logic [7:0] d;
        logic       c;
        int         lat;
        int         e0;
        int         c0;
        run_cmd(2'b00, 3'd4, 3'd0, 3'd0, 8'h33, 1'b1, d, c, lat);
        run_cmd(2'b00, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, d, c, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_rd    = 3'd4;
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd1;
        @(negedge clk);
        e0 = en_cnt;
        c0 = clr_cnt;
        bus.cmd_valid = 1'b0;
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || rf_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: valid=%b en=%b want 0 0", bus.rsp_valid, rf_en);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0
            || en_cnt != e0 || clr_cnt != c0) begin
            errors++;
            $display("FAIL midreset_after: ready=%b valid=%b writes=%0d clears=%0d want 1 0 0 0",
                     bus.cmd_ready, bus.rsp_valid, en_cnt - e0, clr_cnt - c0);
        end
        run_cmd(2'b01, 3'd0, 3'd4, 3'd0, 8'h00, 1'b1, d, c, lat);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("FAIL midreset_keep: data=%h want 33", d);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        en_cnt        = 0;
        clr_cnt       = 0;
        en_wsel       = 3'd0;
        clr_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_rd    = 3'd0;
        bus.cmd_rs1   = 3'd0;
        bus.cmd_rs2   = 3'd0;
        bus.cmd_imm   = 8'h00;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_wri_rd();
        test_add_wrap();
        test_alias();
        test_backpressure();
        test_clr();
        test_reset_mid_add();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
